phase_burst_driver: RTL

- Consumes the two non-overlapping one-cycle phase strobes from the clock prescaler.
- Emits a counted burst of phase-aligned drive pulses on two outputs for the downstream switched-capacitor/charge-pump switches.
- Bursts are launched by a start/busy/done handshake and can be aborted.
- Sits between the prescaler and the analog pin drivers.

---
 rtl/phase_burst_driver.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/phase_burst_driver.sv
// phase_burst_driver
// Turns the prescaler's non-overlapping phi1/phi2 strobes into a counted
// burst of phase-aligned drive pulses for the switched-capacitor switches.
// A burst is requested with start/burst_len, reported through busy/done,
// and can be cancelled with abort. Every output is a flop, so each drive
// pulse trails its strobe by one clock and keeps the prescaler's non-overlap.
//
// Optional feature: define PHASE_GUARD_EN to add the phase-fault guard.
// Simultaneous strobes, or no expected strobe within TIMEOUT clocks while
// waiting, raise a sticky guard_err and drop the burst without done.
// Without the macro there is no timeout counter and guard_err is tied 0.
module phase_burst_driver #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phi1_i,
  input  logic             phi2_i,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  output logic             drv1,
  output logic             drv2,
  output logic             busy,
  output logic             done,
  output logic             guard_err
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_P2,
    WAIT_P1,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             drv1_q, drv1_d;
  logic             drv2_q, drv2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault;

  // Next-state, remaining-pair and output decode for the burst sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    rem_d   = rem_q;
    drv1_d  = 1'b0;
    drv2_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            rem_d   = burst_len;
            state_d = ARM;
          end else begin
            // A zero-length request passes through DONE like any other
            // burst, so done still appears, but busy never rises.
            state_d = DONE;
          end
        end
      end
      // A burst always opens on phi1; a stray phi2 here is ignored.
      ARM, WAIT_P1: begin
        if (phi1_i) begin
          drv1_d  = 1'b1;
          state_d = WAIT_P2;
        end
      end
      WAIT_P2: begin
        if (phi2_i) begin
          drv2_d  = 1'b1;
          rem_d   = rem_q - CNT_W'(1);
          // Leaving at 1 means the counter never wraps below zero.
          state_d = (rem_q == CNT_W'(1)) ? DONE : WAIT_P1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort (outside IDLE) and a guard fault beat strobes and start, kill
    // any pending pulse and suppress done.
    if ((abort && (state_q != IDLE)) || fault) begin
      state_d = IDLE;
      drv1_d  = 1'b0;
      drv2_d  = 1'b0;
      done_d  = 1'b0;
    end

    // busy covers the whole accepted burst including its DONE cycle, but
    // not the DONE cycle of a zero-length request.
    busy_d = (state_d == ARM) || (state_d == WAIT_P1) || (state_d == WAIT_P2) ||
             ((state_d == DONE) && (state_q != IDLE));
  end

  // State, remaining-pair counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      drv1_q  <= 1'b0;
      drv2_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      rem_q   <= rem_d;
      drv1_q  <= drv1_d;
      drv2_q  <= drv2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign drv1 = drv1_q;
  assign drv2 = drv2_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef PHASE_GUARD_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            guard_q, guard_d;
  logic            waiting;
  logic            got_strobe;

  // Fault detection, strobe timeout counting and sticky flag update.
  always_comb begin
    waiting    = (state_q == ARM) || (state_q == WAIT_P1) || (state_q == WAIT_P2);
    got_strobe = (((state_q == ARM) || (state_q == WAIT_P1)) && phi1_i) ||
                 ((state_q == WAIT_P2) && phi2_i);

    // The TIMEOUT-th consecutive waiting clock without the expected strobe
    // is the error cycle.
    fault = (phi1_i && phi2_i) ||
            (waiting && !got_strobe && (to_cnt_q == TO_W'(TIMEOUT - 1)));

    to_cnt_d = '0;
    if (waiting && !got_strobe && !fault && !abort) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    // An accepted start clears the flag; a fault in the same cycle blocks
    // the start and wins.
    guard_d = guard_q;
    if ((state_q == IDLE) && start) begin
      guard_d = 1'b0;
    end
    if (fault) begin
      guard_d = 1'b1;
    end
  end

  // Guard flag and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      guard_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      guard_q  <= guard_d;
    end
  end

  assign guard_err = guard_q;
`else
  // TIMEOUT only matters to the guard; keep it referenced in this build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign fault          = 1'b0;
  assign guard_err      = 1'b0;
`endif

endmodule
